// File: rtl/rwc_rsp_vote.sv
// Majority-vote post-processing of read-write-collision responses: XOR each sample pair, vote per bit,
// emit response + instability mask on a valid/ready port. Define RWC_RSP_HW_EN to build the serial Hamming-weight stage.
module rwc_rsp_vote #(
  parameter int RSP_WIDTH  = 32,
  parameter int VOTE_COUNT = 7,
  localparam int HW_W = $clog2(RSP_WIDTH + 1)
) (
  input  logic                 w_clk,
  input  logic                 w_resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RSP_WIDTH-1:0] in_write,
  input  logic [RSP_WIDTH-1:0] in_clean,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RSP_WIDTH-1:0] out_rsp,
  output logic [RSP_WIDTH-1:0] out_unstable,
  output logic [HW_W-1:0]      out_hw,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshake: a transfer happens on a rising w_clk edge where valid && ready; valid-side data must
  // hold while valid is high and ready low. in_ready is a pure decode of state, all else is registered.

  localparam int CW = $clog2(VOTE_COUNT + 1);

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DECIDE = 2'd1,
`ifdef RWC_RSP_HW_EN
    ST_POPCNT = 2'd2,
`endif
    ST_OUT    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         smp_cnt_q, smp_cnt_d;
  logic [CW-1:0]         cnt_q [RSP_WIDTH];
  logic [CW-1:0]         cnt_d [RSP_WIDTH];
  logic [RSP_WIDTH-1:0]  rsp_q, rsp_d;
  logic [RSP_WIDTH-1:0]  unst_q, unst_d;
  logic [RSP_WIDTH-1:0]  raw;
  logic                  accept;

`ifdef RWC_RSP_HW_EN
  localparam int IDX_W = (RSP_WIDTH > 1) ? $clog2(RSP_WIDTH) : 1;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [HW_W-1:0]       acc_q, acc_d;
  logic [HW_W-1:0]       hw_q, hw_d;
`endif

  assign raw    = in_write ^ in_clean;
  assign accept = in_valid && (state_q == ST_ACCUM);

  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    cnt_d     = cnt_q;
    rsp_d     = rsp_q;
    unst_d    = unst_q;
`ifdef RWC_RSP_HW_EN
    idx_d     = idx_q;
    acc_d     = acc_q;
    hw_d      = hw_q;
`endif
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          for (int i = 0; i < RSP_WIDTH; i++) begin
            cnt_d[i] = cnt_q[i] + CW'(raw[i]);
          end
          smp_cnt_d = smp_cnt_q + CW'(1);
          if (smp_cnt_q == CW'(VOTE_COUNT - 1)) begin
            state_d = ST_DECIDE;
          end
        end
      end
      ST_DECIDE: begin
        // A bit is unstable unless every sample agreed, i.e. its count is 0 or VOTE_COUNT.
        for (int i = 0; i < RSP_WIDTH; i++) begin
          rsp_d[i]  = cnt_q[i] > CW'(VOTE_COUNT / 2);
          unst_d[i] = (cnt_q[i] != '0) && (cnt_q[i] != CW'(VOTE_COUNT));
          cnt_d[i]  = '0;
        end
        smp_cnt_d = '0;
`ifdef RWC_RSP_HW_EN
        idx_d   = '0;
        acc_d   = '0;
        state_d = ST_POPCNT;
`else
        state_d = ST_OUT;
`endif
      end
`ifdef RWC_RSP_HW_EN
      ST_POPCNT: begin
        acc_d = acc_q + HW_W'(rsp_q[idx_q]);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(RSP_WIDTH - 1)) begin
          hw_d    = acc_q + HW_W'(rsp_q[idx_q]);
          state_d = ST_OUT;
        end
      end
`endif
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_resetn) begin
      state_q   <= ST_ACCUM;
      smp_cnt_q <= '0;
      rsp_q     <= '0;
      unst_q    <= '0;
      for (int i = 0; i < RSP_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef RWC_RSP_HW_EN
      idx_q     <= '0;
      acc_q     <= '0;
      hw_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      rsp_q     <= rsp_d;
      unst_q    <= unst_d;
      for (int i = 0; i < RSP_WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef RWC_RSP_HW_EN
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      hw_q      <= hw_d;
`endif
    end
  end

  assign in_ready     = (state_q == ST_ACCUM);
  assign out_valid    = (state_q == ST_OUT);
  assign out_rsp      = rsp_q;
  assign out_unstable = unst_q;
  assign busy         = !((state_q == ST_ACCUM) && (smp_cnt_q == '0));
  assign dbg_state    = state_q;
`ifdef RWC_RSP_HW_EN
  assign out_hw       = hw_q;
`else
  assign out_hw       = '0;
`endif

endmodule

// File: tb/tb_rwc_rsp_vote.sv
// Bench for rwc_rsp_vote: a VOTE_COUNT=3 instance driven from a vector table and corner sequences,
// plus a VOTE_COUNT=1 instance; results are checked through an expected-value queue.
module tb_rwc_rsp_vote;
  localparam int W    = 32;
  localparam int HW_W = 6;
`ifdef RWC_RSP_HW_EN
  localparam bit HW_ON = 1'b1;
`else
  localparam bit HW_ON = 1'b0;
`endif
  localparam int LAT = HW_ON ? (1 + W) : 1;

  // ---------------- clock / reset ----------------
  logic w_clk = 1'b0;
  logic w_resetn;
  int   cyc = 0;
  always #5 w_clk = ~w_clk;
  always @(posedge w_clk) cyc <= cyc + 1;

  // dut3: VOTE_COUNT=3, dut1: VOTE_COUNT=1
  logic            in_valid3, in_ready3, out_valid3, out_ready3, busy3;
  logic [W-1:0]    in_write3, in_clean3, out_rsp3, out_unst3;
  logic [HW_W-1:0] out_hw3;
  logic [1:0]      dbg3;
  logic            in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [W-1:0]    in_write1, in_clean1, out_rsp1, out_unst1;
  logic [HW_W-1:0] out_hw1;
  logic [1:0]      dbg1;

  rwc_rsp_vote #(.RSP_WIDTH(W), .VOTE_COUNT(3)) dut3 (
    .w_clk(w_clk), .w_resetn(w_resetn), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_write(in_write3), .in_clean(in_clean3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_rsp(out_rsp3), .out_unstable(out_unst3), .out_hw(out_hw3), .busy(busy3), .dbg_state(dbg3));

  rwc_rsp_vote #(.RSP_WIDTH(W), .VOTE_COUNT(1)) dut1 (
    .w_clk(w_clk), .w_resetn(w_resetn), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_write(in_write1), .in_clean(in_clean1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_rsp(out_rsp1), .out_unstable(out_unst1), .out_hw(out_hw1), .busy(busy1), .dbg_state(dbg1));

  // ---------------- scoreboard ----------------
  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    exp_unst_q[$];
  logic [HW_W-1:0] exp_hw_q[$];
  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? in_ready3 : in_ready1;
  endfunction
  function automatic logic ovld(input int d);
    return (d == 0) ? out_valid3 : out_valid1;
  endfunction
  function automatic logic [W-1:0] orsp(input int d);
    return (d == 0) ? out_rsp3 : out_rsp1;
  endfunction
  function automatic logic [W-1:0] ounst(input int d);
    return (d == 0) ? out_unst3 : out_unst1;
  endfunction
  function automatic logic [HW_W-1:0] ohw(input int d);
    return (d == 0) ? out_hw3 : out_hw1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input int d, input logic v, input logic [W-1:0] wr, input logic [W-1:0] cl);
    if (d == 0) begin
      in_valid3 = v; in_write3 = wr; in_clean3 = cl;
    end else begin
      in_valid1 = v; in_write1 = wr; in_clean1 = cl;
    end
  endtask

  task automatic set_ordy(input int d, input logic v);
    if (d == 0) out_ready3 = v;
    else        out_ready1 = v;
  endtask

  task automatic push_exp(input logic [W-1:0] r, input logic [W-1:0] u, input logic [HW_W-1:0] h);
    exp_q.push_back(r);
    exp_unst_q.push_back(u);
    exp_hw_q.push_back(HW_ON ? h : '0);
  endtask

  task automatic drive_sample(input int d, input logic [W-1:0] x);
    logic [W-1:0] c;
    int budget;
    c = $urandom;
    @(negedge w_clk);
    set_in(d, 1'b1, x ^ c, c);
    budget = 20;
    while (!rdy(d) && budget > 0) begin
      @(negedge w_clk);
      budget--;
    end
    if (!rdy(d)) check("in_ready_timeout", {31'd0, rdy(d)}, 32'd1);
    @(posedge w_clk);
    #1;
    acc_cyc = cyc;
    set_in(d, 1'b0, '0, '0);
  endtask

  // Wait for out_valid, compare against the queue head, optionally stall, then take the result.
  task automatic wait_result(input int d, input int hold);
    logic [W-1:0]    er, eu;
    logic [HW_W-1:0] eh;
    int budget;
    er = exp_q.pop_front();
    eu = exp_unst_q.pop_front();
    eh = exp_hw_q.pop_front();
    budget = 200;
    do begin
      @(negedge w_clk);
      budget--;
    end while (!ovld(d) && budget > 0);
    if (!ovld(d)) begin
      check("out_valid_timeout", {31'd0, ovld(d)}, 32'd1);
    end else begin
      check("latency", 32'(cyc - acc_cyc), 32'(LAT));
      check("out_rsp", orsp(d), er);
      check("out_unstable", ounst(d), eu);
      check("out_hw", 32'(ohw(d)), 32'(eh));
      for (int k = 0; k < hold; k++) begin
        set_in(d, 1'b1, $urandom, $urandom);
        @(negedge w_clk);
        check("bp_out_valid", {31'd0, ovld(d)}, 32'd1);
        check("bp_in_ready", {31'd0, rdy(d)}, 32'd0);
        check("bp_out_rsp", orsp(d), er);
      end
      set_in(d, 1'b0, '0, '0);
      set_ordy(d, 1'b1);
      @(posedge w_clk);
      #1;
      set_ordy(d, 1'b0);
      check("post_out_valid", {31'd0, ovld(d)}, 32'd0);
      check("post_in_ready", {31'd0, rdy(d)}, 32'd1);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0]    x0, x1, x2;
    logic [W-1:0]    rsp, unst;
    logic [HW_W-1:0] hw;
    bit              early;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0000, 6'd16, 1'b0};
    tbl[1] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0003, 6'd2,  1'b1};
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 6'd0,  1'b0};
    tbl[3] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000, 32'hF000_F000, 32'hFFF0_FFF0, 6'd8,  1'b0};
    tbl[4] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 6'd13, 1'b1};
    tbl[5] = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd32, 1'b0};

    w_resetn = 1'b0;
    set_in(0, 1'b0, '0, '0);
    set_in(1, 1'b0, '0, '0);
    out_ready3 = 1'b0;
    out_ready1 = 1'b0;
    repeat (3) @(posedge w_clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready3}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid3}, 32'd0);
    check("rst_out_rsp", out_rsp3, 32'd0);
    check("rst_out_unstable", out_unst3, 32'd0);
    check("rst_out_hw", 32'(out_hw3), 32'd0);
    check("rst_busy", {31'd0, busy3}, 32'd0);
    check("rst_state", 32'(dbg3), 32'd0);
    @(negedge w_clk);
    w_resetn = 1'b1;

    for (int v = 0; v < 6; v++) begin
      push_exp(tbl[v].rsp, tbl[v].unst, tbl[v].hw);
      if (tbl[v].early) set_ordy(0, 1'b1);
      drive_sample(0, tbl[v].x0);
      drive_sample(0, tbl[v].x1);
      drive_sample(0, tbl[v].x2);
      wait_result(0, 0);
    end

    // Reset mid-batch: outputs still hold FFFF_FFFF from the last vector.
    drive_sample(0, 32'hFFFF_FFFF);
    drive_sample(0, 32'hFFFF_FFFF);
    check("mid_busy", {31'd0, busy3}, 32'd1);
    @(negedge w_clk);
    w_resetn = 1'b0;
    @(posedge w_clk);
    #1;
    check("mrst_out_rsp", out_rsp3, 32'd0);
    check("mrst_out_unstable", out_unst3, 32'd0);
    check("mrst_out_hw", 32'(out_hw3), 32'd0);
    check("mrst_out_valid", {31'd0, out_valid3}, 32'd0);
    check("mrst_busy", {31'd0, busy3}, 32'd0);
    @(negedge w_clk);
    w_resetn = 1'b1;
    push_exp(32'd0, 32'd0, 6'd0);
    for (int s = 0; s < 3; s++) drive_sample(0, 32'd0);
    wait_result(0, 0);

    // Backpressure: hold the result 10 cycles while offering samples that must be ignored.
    push_exp(32'h0F0F_0F0F, 32'd0, 6'd16);
    for (int s = 0; s < 3; s++) drive_sample(0, 32'h0F0F_0F0F);
    wait_result(0, 10);
    push_exp(32'd0, 32'd0, 6'd0);
    drive_sample(0, 32'd0);
    drive_sample(0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge w_clk);
      check("partial_no_valid", {31'd0, out_valid3}, 32'd0);
    end
    check("partial_busy", {31'd0, busy3}, 32'd1);
    drive_sample(0, 32'd0);
    wait_result(0, 0);

    // VOTE_COUNT=1: each sample is its own vote.
    push_exp(32'hA5A5_A5A5, 32'd0, 6'd16);
    drive_sample(1, 32'hA5A5_A5A5);
    wait_result(1, 0);
    push_exp(32'h8000_0001, 32'd0, 6'd2);
    drive_sample(1, 32'h8000_0001);
    wait_result(1, 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
